// File: rtl/mips_mem_stage.sv
// MIPS MEM stage: word-addressed data RAM, one-cycle MEM/WB pulse, sticky HALT.
// Optional range checking of load/store addresses under MEM_BOUNDS_CHK_EN.
module mips_mem_stage #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    output logic        in_ready,
    output logic        out_valid,
    output logic [2:0]  out_type,
    output logic [31:0] out_alu,
    output logic [31:0] out_lmd,
    output logic [4:0]  out_rd,
    output logic        halted,
    output logic        addr_err
);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_e;

    localparam logic [2:0] T_LOAD  = 3'd1;
    localparam logic [2:0] T_STORE = 3'd2;
    localparam logic [2:0] T_HALT  = 3'd3;

    logic [31:0] Mem [DEPTH];

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [2:0]  out_type_q, out_type_d;
    logic [31:0] out_alu_q, out_alu_d;
    logic [31:0] out_lmd_q, out_lmd_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    // Load in flight: sideband captured on accept, emitted from LOAD_WAIT
    logic [31:0] pend_alu_q, pend_alu_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_oob_q, pend_oob_d;
    logic [31:0] rdata_q;

    logic          accept;
    logic          oob;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] idx;

    assign in_ready = (state_q == IDLE) && !halted_q;
    assign accept   = in_valid && in_ready;
    assign idx      = in_alu[AW-1:0];

`ifdef MEM_BOUNDS_CHK_EN
    assign oob      = (in_alu >= 32'(DEPTH));
    assign addr_err = err_q;
`else
    logic unused_hi;
    assign unused_hi = ^{in_alu[31:AW], err_q};
    assign oob       = 1'b0;
    assign addr_err  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_type_d  = out_type_q;
        out_alu_d   = out_alu_q;
        out_lmd_d   = out_lmd_q;
        out_rd_d    = out_rd_q;
        halted_d    = halted_q;
        err_d       = err_q;
        pend_alu_d  = pend_alu_q;
        pend_rd_d   = pend_rd_q;
        pend_oob_d  = pend_oob_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        if (state_q == LOAD_WAIT) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            out_type_d  = T_LOAD;
            out_alu_d   = pend_alu_q;
            out_rd_d    = pend_rd_q;
            out_lmd_d   = pend_oob_q ? 32'd0 : rdata_q;
        end else if (accept) begin
            if (in_type == T_LOAD) begin
                state_d    = LOAD_WAIT;
                mem_re     = 1'b1;
                pend_alu_d = in_alu;
                pend_rd_d  = in_rd;
                pend_oob_d = oob;
                err_d      = err_q | oob;
            end else begin
                out_valid_d = 1'b1;
                out_type_d  = in_type;
                out_alu_d   = in_alu;
                out_rd_d    = in_rd;
                if (in_type == T_STORE) begin
                    mem_we = !rst && !oob;
                    err_d  = err_q | oob;
                end
                if (in_type == T_HALT) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_type_q  <= 3'd0;
            out_alu_q   <= 32'd0;
            out_lmd_q   <= 32'd0;
            out_rd_q    <= 5'd0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            pend_alu_q  <= 32'd0;
            pend_rd_q   <= 5'd0;
            pend_oob_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_alu_q   <= out_alu_d;
            out_lmd_q   <= out_lmd_d;
            out_rd_q    <= out_rd_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            pend_alu_q  <= pend_alu_d;
            pend_rd_q   <= pend_rd_d;
            pend_oob_q  <= pend_oob_d;
        end
    end

    // RAM is never reset; a store in the reset cycle is blocked via mem_we
    always_ff @(posedge clk1) begin
        if (mem_we) begin
            Mem[idx] <= in_b;
        end
        if (mem_re) begin
            rdata_q <= Mem[idx];
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_alu   = out_alu_q;
    assign out_lmd   = out_lmd_q;
    assign out_rd    = out_rd_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mips_mem_stage.sv
// Directed bench for mips_mem_stage: vector table plus load/reset/halt/bounds sequences.
// Build with +define+MEM_BOUNDS_CHK_EN to exercise the range-checked variant.
module tb_mips_mem_stage;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_type;
    logic [31:0] in_alu;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        in_ready;
    logic        out_valid;
    logic [2:0]  out_type;
    logic [31:0] out_alu;
    logic [31:0] out_lmd;
    logic [4:0]  out_rd;
    logic        halted;
    logic        addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mem_stage #(.DEPTH(1024), .AW(10)) dut (
        .clk1     (clk1),
        .rst      (rst),
        .in_valid (in_valid),
        .in_type  (in_type),
        .in_alu   (in_alu),
        .in_b     (in_b),
        .in_rd    (in_rd),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_type (out_type),
        .out_alu  (out_alu),
        .out_lmd  (out_lmd),
        .out_rd   (out_rd),
        .halted   (halted),
        .addr_err (addr_err)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [2:0]  e_type;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r);
        in_valid = 1'b1;
        in_type  = t;
        in_alu   = a;
        in_b     = b;
        in_rd    = r;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_type  = 3'd4;
        in_alu   = 32'd0;
        in_b     = 32'd0;
        in_rd    = 5'd0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] b);
        drive(3'd2, a, b, 5'd0);
        step();
        idle();
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'h0000_1234, 32'h0, 5'd4,  3'd0, 32'h0000_1234, 5'd4};
        vecs[1] = '{3'd5, 32'hdead_beef, 32'h0, 5'd31, 3'd5, 32'hdead_beef, 5'd31};
        vecs[2] = '{3'd2, 32'd100, 32'd5555, 5'd0,     3'd2, 32'd100, 5'd0};
        vecs[3] = '{3'd0, 32'hffff_ffff, 32'h0, 5'd1,  3'd0, 32'hffff_ffff, 5'd1};
        vecs[4] = '{3'd2, 32'd3, 32'h0000_aaaa, 5'd2,  3'd2, 32'd3, 5'd2};
        vecs[5] = '{3'd7, 32'h0000_0042, 32'h0, 5'd17, 3'd7, 32'h0000_0042, 5'd17};

        rst = 1'b1;
        idle();
        step();
        step();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_type",  32'(out_type),  32'd0);
        chk("rst out_alu",   out_alu,        32'd0);
        chk("rst out_lmd",   out_lmd,        32'd0);
        chk("rst out_rd",    32'(out_rd),    32'd0);
        chk("rst halted",    32'(halted),    32'd0);
        chk("rst addr_err",  32'(addr_err),  32'd0);
        chk("rst in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].typ, vecs[i].alu, vecs[i].b, vecs[i].rd);
            step();
            idle();
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d type", i),  32'(out_type),  32'(vecs[i].e_type));
            chk($sformatf("v%0d alu", i),   out_alu,        vecs[i].e_alu);
            chk($sformatf("v%0d rd", i),    32'(out_rd),    32'(vecs[i].e_rd));
            chk($sformatf("v%0d lmd", i),   out_lmd,        32'd0);
            step();
            chk($sformatf("v%0d pulse", i), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d hold", i),  out_alu,        vecs[i].e_alu);
        end
        chk("mem100", dut.Mem[100], 32'd5555);
        chk("mem3",   dut.Mem[3],   32'h0000_aaaa);

        // load latency 2, in_ready low in LOAD_WAIT
        drive(3'd1, 32'd100, 32'd0, 5'd9);
        step();
        idle();
        chk("ld ready low", 32'(in_ready),  32'd0);
        chk("ld no early",  32'(out_valid), 32'd0);
        step();
        chk("ld valid", 32'(out_valid), 32'd1);
        chk("ld lmd",   out_lmd,        32'd5555);
        chk("ld type",  32'(out_type),  32'd1);
        chk("ld rd",    32'(out_rd),    32'd9);
        chk("ld alu",   out_alu,        32'd100);
        chk("ld ready", 32'(in_ready),  32'd1);
        step();
        chk("ld pulse", 32'(out_valid), 32'd0);
        chk("ld hold",  out_lmd,        32'd5555);

        // store then load same address back to back
        drive(3'd2, 32'd3, 32'd7, 5'd0);
        step();
        chk("st3 valid", 32'(out_valid), 32'd1);
        chk("st3 rdy",   32'(in_ready),  32'd1);
        drive(3'd1, 32'd3, 32'd0, 5'd6);
        step();
        idle();
        chk("bb ready low", 32'(in_ready),  32'd0);
        chk("bb no valid",  32'(out_valid), 32'd0);
        step();
        chk("bb valid", 32'(out_valid), 32'd1);
        chk("bb lmd",   out_lmd,        32'd7);
        chk("bb ready", 32'(in_ready),  32'd1);

        // reset aborts an in-flight load
        drive(3'd1, 32'd100, 32'd0, 5'd12);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ab valid",  32'(out_valid), 32'd0);
        chk("ab lmd",    out_lmd,        32'd0);
        chk("ab alu",    out_alu,        32'd0);
        chk("ab rd",     32'(out_rd),    32'd0);
        chk("ab type",   32'(out_type),  32'd0);
        chk("ab ready",  32'(in_ready),  32'd1);
        chk("ab mem",    dut.Mem[100],   32'd5555);
        step();
        chk("ab late", 32'(out_valid), 32'd0);

        // store in reset cycle must not write
        do_store(32'd50, 32'h11);
        step();
        rst = 1'b1;
        drive(3'd2, 32'd50, 32'h99, 5'd0);
        step();
        rst = 1'b0;
        idle();
        chk("rst st mem",   dut.Mem[50],    32'h11);
        chk("rst st valid", 32'(out_valid), 32'd0);

        // address beyond DEPTH
        do_store(32'd2, 32'h22);
        step();
        drive(3'd2, 32'd1026, 32'd1, 5'd0);
        step();
        idle();
        chk("oob st valid", 32'(out_valid), 32'd2 - 32'd1);
`ifdef MEM_BOUNDS_CHK_EN
        chk("oob err", 32'(addr_err), 32'd1);
        chk("oob mem", dut.Mem[2],    32'h22);
        drive(3'd1, 32'd1026, 32'd0, 5'd3);
        step();
        idle();
        step();
        chk("oob ld valid", 32'(out_valid), 32'd1);
        chk("oob ld lmd",   out_lmd,        32'd0);
        chk("oob sticky",   32'(addr_err),  32'd1);
`else
        chk("wrap err", 32'(addr_err), 32'd0);
        chk("wrap mem", dut.Mem[2],    32'd1);
        drive(3'd1, 32'd1026, 32'd0, 5'd3);
        step();
        idle();
        step();
        chk("wrap ld valid", 32'(out_valid), 32'd1);
        chk("wrap ld lmd",   out_lmd,        32'd1);
`endif
        step();

        // HALT blocks further entries and writes
        do_store(32'd5, 32'h55);
        step();
        drive(3'd3, 32'd0, 32'd0, 5'd0);
        step();
        chk("halt valid", 32'(out_valid), 32'd1);
        chk("halt type",  32'(out_type),  32'd3);
        chk("halted",     32'(halted),    32'd1);
        chk("halt ready", 32'(in_ready),  32'd0);
        drive(3'd2, 32'd5, 32'd9, 5'd0);
        step();
        chk("post halt valid", 32'(out_valid), 32'd0);
        step();
        idle();
        chk("post halt mem",    dut.Mem[5],     32'h55);
        chk("post halt ready",  32'(in_ready),  32'd0);
        chk("post halt sticky", 32'(halted),    32'd1);
        chk("post halt quiet",  32'(out_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("halt clr", 32'(halted),   32'd0);
        chk("halt rdy", 32'(in_ready), 32'd1);
        chk("halt mem", dut.Mem[5],    32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
